// File: rtl/md5_block_sequencer.sv
`default_nettype none
// ============================================================================
// md5_block_sequencer : iterative MD5 compression, one step per clock
// Revision 1.0 - initial release
// ============================================================================

// One MD5 step of a given round type; message word index derived from step.
module md5_round #(
    parameter int ROUND_TYPE = 0
) (
    input  logic [31:0]  a_i,
    input  logic [31:0]  b_i,
    input  logic [31:0]  c_i,
    input  logic [31:0]  d_i,
    input  logic [511:0] msg_i,
    input  logic [31:0]  k_i,
    input  logic [4:0]   s_i,
    input  logic [3:0]   step_i,
    output logic [31:0]  a_o,
    output logic [31:0]  b_o,
    output logic [31:0]  c_o,
    output logic [31:0]  d_o
);
    logic [31:0] f_w;
    logic [3:0]  g_w;
    logic [31:0] sum_w;
    logic [31:0] rot_w;

    always_comb begin
        f_w = '0;
        g_w = '0;
        case (ROUND_TYPE)
            0: begin
                f_w = (b_i & c_i) | (~b_i & d_i);
                g_w = step_i;
            end
            1: begin
                f_w = (d_i & b_i) | (~d_i & c_i);
                g_w = step_i * 4'd5 + 4'd1;
            end
            2: begin
                f_w = b_i ^ c_i ^ d_i;
                g_w = step_i * 4'd3 + 4'd5;
            end
            default: begin
                f_w = c_i ^ (b_i | ~d_i);
                g_w = step_i * 4'd7;
            end
        endcase
    end

    assign sum_w = a_i + f_w + k_i + msg_i[32*g_w +: 32];
    // Shift amounts are always 4..23, so both halves of the rotate are valid
    assign rot_w = (sum_w << s_i) | (sum_w >> (6'd32 - {1'b0, s_i}));

    assign a_o = d_i;
    assign b_o = b_i + rot_w;
    assign c_o = b_i;
    assign d_o = c_i;
endmodule

module md5_block_sequencer (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] message,
    input  logic [31:0]  a_in,
    input  logic [31:0]  b_in,
    input  logic [31:0]  c_in,
    input  logic [31:0]  d_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  a_out,
    output logic [31:0]  b_out,
    output logic [31:0]  c_out,
    output logic [31:0]  d_out,
    output logic         busy,
    output logic [5:0]   round_num
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [5:0]   r_q, r_d;
    logic [511:0] msg_q, msg_d;
    logic [127:0] init_q, init_d;
    logic [127:0] work_q, work_d;

    logic [3:0][31:0] ra_w, rb_w, rc_w, rd_w;
    logic [31:0]      k_w;
    logic [4:0]       s_w;

    function automatic logic [31:0] k_lookup(input logic [5:0] idx);
        case (idx)
            6'd0:  k_lookup = 32'hd76aa478;  6'd1:  k_lookup = 32'he8c7b756;
            6'd2:  k_lookup = 32'h242070db;  6'd3:  k_lookup = 32'hc1bdceee;
            6'd4:  k_lookup = 32'hf57c0faf;  6'd5:  k_lookup = 32'h4787c62a;
            6'd6:  k_lookup = 32'ha8304613;  6'd7:  k_lookup = 32'hfd469501;
            6'd8:  k_lookup = 32'h698098d8;  6'd9:  k_lookup = 32'h8b44f7af;
            6'd10: k_lookup = 32'hffff5bb1;  6'd11: k_lookup = 32'h895cd7be;
            6'd12: k_lookup = 32'h6b901122;  6'd13: k_lookup = 32'hfd987193;
            6'd14: k_lookup = 32'ha679438e;  6'd15: k_lookup = 32'h49b40821;
            6'd16: k_lookup = 32'hf61e2562;  6'd17: k_lookup = 32'hc040b340;
            6'd18: k_lookup = 32'h265e5a51;  6'd19: k_lookup = 32'he9b6c7aa;
            6'd20: k_lookup = 32'hd62f105d;  6'd21: k_lookup = 32'h02441453;
            6'd22: k_lookup = 32'hd8a1e681;  6'd23: k_lookup = 32'he7d3fbc8;
            6'd24: k_lookup = 32'h21e1cde6;  6'd25: k_lookup = 32'hc33707d6;
            6'd26: k_lookup = 32'hf4d50d87;  6'd27: k_lookup = 32'h455a14ed;
            6'd28: k_lookup = 32'ha9e3e905;  6'd29: k_lookup = 32'hfcefa3f8;
            6'd30: k_lookup = 32'h676f02d9;  6'd31: k_lookup = 32'h8d2a4c8a;
            6'd32: k_lookup = 32'hfffa3942;  6'd33: k_lookup = 32'h8771f681;
            6'd34: k_lookup = 32'h6d9d6122;  6'd35: k_lookup = 32'hfde5380c;
            6'd36: k_lookup = 32'ha4beea44;  6'd37: k_lookup = 32'h4bdecfa9;
            6'd38: k_lookup = 32'hf6bb4b60;  6'd39: k_lookup = 32'hbebfbc70;
            6'd40: k_lookup = 32'h289b7ec6;  6'd41: k_lookup = 32'heaa127fa;
            6'd42: k_lookup = 32'hd4ef3085;  6'd43: k_lookup = 32'h04881d05;
            6'd44: k_lookup = 32'hd9d4d039;  6'd45: k_lookup = 32'he6db99e5;
            6'd46: k_lookup = 32'h1fa27cf8;  6'd47: k_lookup = 32'hc4ac5665;
            6'd48: k_lookup = 32'hf4292244;  6'd49: k_lookup = 32'h432aff97;
            6'd50: k_lookup = 32'hab9423a7;  6'd51: k_lookup = 32'hfc93a039;
            6'd52: k_lookup = 32'h655b59c3;  6'd53: k_lookup = 32'h8f0ccc92;
            6'd54: k_lookup = 32'hffeff47d;  6'd55: k_lookup = 32'h85845dd1;
            6'd56: k_lookup = 32'h6fa87e4f;  6'd57: k_lookup = 32'hfe2ce6e0;
            6'd58: k_lookup = 32'ha3014314;  6'd59: k_lookup = 32'h4e0811a1;
            6'd60: k_lookup = 32'hf7537e82;  6'd61: k_lookup = 32'hbd3af235;
            6'd62: k_lookup = 32'h2ad7d2bb;  default: k_lookup = 32'heb86d391;
        endcase
    endfunction

    function automatic logic [4:0] s_lookup(input logic [5:0] idx);
        case ({idx[5:4], idx[1:0]})
            4'h0: s_lookup = 5'd7;   4'h1: s_lookup = 5'd12;
            4'h2: s_lookup = 5'd17;  4'h3: s_lookup = 5'd22;
            4'h4: s_lookup = 5'd5;   4'h5: s_lookup = 5'd9;
            4'h6: s_lookup = 5'd14;  4'h7: s_lookup = 5'd20;
            4'h8: s_lookup = 5'd4;   4'h9: s_lookup = 5'd11;
            4'ha: s_lookup = 5'd16;  4'hb: s_lookup = 5'd23;
            4'hc: s_lookup = 5'd6;   4'hd: s_lookup = 5'd10;
            4'he: s_lookup = 5'd15;  default: s_lookup = 5'd21;
        endcase
    endfunction

    assign k_w = k_lookup(r_q);
    assign s_w = s_lookup(r_q);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_round
            md5_round #(.ROUND_TYPE(gi)) u_round (
                .a_i    (work_q[127:96]),
                .b_i    (work_q[95:64]),
                .c_i    (work_q[63:32]),
                .d_i    (work_q[31:0]),
                .msg_i  (msg_q),
                .k_i    (k_w),
                .s_i    (s_w),
                .step_i (r_q[3:0]),
                .a_o    (ra_w[gi]),
                .b_o    (rb_w[gi]),
                .c_o    (rc_w[gi]),
                .d_o    (rd_w[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            msg_q   <= '0;
            init_q  <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            msg_q   <= msg_d;
            init_q  <= init_d;
            work_q  <= work_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        msg_d   = msg_q;
        init_d  = init_q;
        work_d  = work_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    msg_d   = message;
                    init_d  = {a_in, b_in, c_in, d_in};
                    work_d  = {a_in, b_in, c_in, d_in};
                    r_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                work_d = {ra_w[r_q[5:4]], rb_w[r_q[5:4]], rc_w[r_q[5:4]], rd_w[r_q[5:4]]};
                // Counter parks at 63 so round_num stays observable through FINAL/DONE
                if (r_q == 6'd63) begin
                    state_d = ST_FINAL;
                end else begin
                    r_d = r_q + 6'd1;
                end
            end
            ST_FINAL: begin
                work_d = {work_q[127:96] + init_q[127:96], work_q[95:64] + init_q[95:64],
                          work_q[63:32]  + init_q[63:32],  work_q[31:0]  + init_q[31:0]};
                state_d = ST_DONE;
            end
            default: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_RUN) || (state_q == ST_FINAL);
    end

    assign round_num = r_q;
    assign a_out     = work_q[127:96];
    assign b_out     = work_q[95:64];
    assign c_out     = work_q[63:32];
    assign d_out     = work_q[31:0];
endmodule
`default_nettype wire

// File: tb/tb_md5_block_sequencer.sv
`default_nettype none
// ============================================================================
// tb_md5_block_sequencer : cycle model + MD5 reference for md5_block_sequencer
// Revision 1.0 - initial release
// ============================================================================
module tb_md5_block_sequencer;
    logic         clk = 1'b0;
    logic         reset, in_valid, out_ready;
    logic [511:0] message;
    logic [31:0]  a_in, b_in, c_in, d_in;
    logic         in_ready, out_valid, busy;
    logic [31:0]  a_out, b_out, c_out, d_out;
    logic [5:0]   round_num;

    always #5 clk = ~clk;

    md5_block_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .message   (message),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .d_in      (d_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .b_out     (b_out),
        .c_out     (c_out),
        .d_out     (d_out),
        .busy      (busy),
        .round_num (round_num)
    );

    localparam logic [127:0] IV        = 128'h67452301_efcdab89_98badcfe_10325476;
    localparam logic [127:0] DIG_EMPTY = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec;
    localparam logic [127:0] DIG_ABC   = 128'h98500190_b04fd23c_7d3f96d6_727fe128;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [31:0]  kt [64];
    logic [511:0] blk_empty, blk_abc;

    // Transaction-level model: 0 idle, 1 computing, 2 digest held
    int           m_mode  = 0;
    int           m_cnt   = 0;
    logic [5:0]   m_round = '0;
    logic [127:0] m_dig   = '0;
    bit           m_acc   = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic int shift_of(input int i);
        int q;
        q = i % 4;
        case (i / 16)
            0:       return (q == 0) ? 7 : (q == 1) ? 12 : (q == 2) ? 17 : 22;
            1:       return (q == 0) ? 5 : (q == 1) ? 9  : (q == 2) ? 14 : 20;
            2:       return (q == 0) ? 4 : (q == 1) ? 11 : (q == 2) ? 16 : 23;
            default: return (q == 0) ? 6 : (q == 1) ? 10 : (q == 2) ? 15 : 21;
        endcase
    endfunction

    function automatic logic [127:0] md5_ref(input logic [511:0] m, input logic [127:0] st);
        logic [31:0] a, b, c, d, f, t;
        int g;
        {a, b, c, d} = st;
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0:       begin f = (b & c) | (~b & d); g = i;                end
                1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
                2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
            endcase
            t = a + f + kt[i] + m[32*g +: 32];
            a = d;
            d = c;
            c = b;
            b = b + rotl(t, shift_of(i));
        end
        return {st[127:96] + a, st[95:64] + b, st[63:32] + c, st[31:0] + d};
    endfunction

    // One clock: advance the model on the edge, compare on the falling edge
    task automatic tick();
        @(posedge clk);
        m_acc = 1'b0;
        if (reset) begin
            m_mode  = 0;
            m_round = '0;
        end else begin
            case (m_mode)
                0: if (in_valid) begin
                    m_mode  = 1;
                    m_cnt   = 0;
                    m_round = '0;
                    m_dig   = md5_ref(message, {a_in, b_in, c_in, d_in});
                    m_acc   = 1'b1;
                end
                1: begin
                    m_cnt++;
                    m_round = (m_cnt > 63) ? 6'd63 : 6'(m_cnt);
                    if (m_cnt == 65) m_mode = 2;
                end
                default: if (out_ready) m_mode = 0;
            endcase
        end
        @(negedge clk);
        check("in_ready", in_ready, m_mode == 0);
        check("out_valid", out_valid, m_mode == 2);
        check("busy", busy, m_mode == 1);
        check("round_num", round_num, m_round);
        if (m_mode == 2) check("digest", {a_out, b_out, c_out, d_out}, m_dig);
    endtask

    task automatic set_block(input logic [511:0] m, input logic [127:0] st);
        message = m;
        {a_in, b_in, c_in, d_in} = st;
    endtask

    task automatic send(input logic [511:0] m, input logic [127:0] st);
        int k;
        set_block(m, st);
        in_valid = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (!m_acc && k < 200);
        if (!m_acc) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        // Scramble inputs: only the latched copies may be used
        message  = {16{$urandom}};
        {a_in, b_in, c_in, d_in} = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        if (!out_valid) check("valid_timeout", 0, 1);
    endtask

    initial begin
        int           n, acc, nv, k, stray;
        int           vt [2];
        logic [127:0] vd [2];
        logic [127:0] held;

        for (int i = 0; i < 64; i++) begin
            real    v;
            longint q;
            v = $sin(real'(i + 1));
            if (v < 0.0) v = -v;
            q = longint'($floor(v * 4294967296.0));
            kt[i] = q[31:0];
        end
        blk_empty         = '0;
        blk_empty[31:0]   = 32'h00000080;
        blk_abc           = '0;
        blk_abc[31:0]     = 32'h80636261;
        blk_abc[479:448]  = 32'h00000018;

        check("k_first", kt[0], 32'hd76aa478);
        check("k_last", kt[63], 32'heb86d391);
        check("ref_empty", md5_ref(blk_empty, IV), DIG_EMPTY);
        check("ref_abc", md5_ref(blk_abc, IV), DIG_ABC);

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_block('0, '0);
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_round", round_num, 0);
        check("rst_digest", {a_out, b_out, c_out, d_out}, 0);

        // Empty-string block with exact latency
        send(blk_empty, IV);
        wait_valid(n);
        check("latency", n, 65);
        check("empty_digest", {a_out, b_out, c_out, d_out}, DIG_EMPTY);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Backpressure with a competing block offered during the stall
        send(blk_abc, IV);
        wait_valid(n);
        held = {a_out, b_out, c_out, d_out};
        check("abc_digest", held, DIG_ABC);
        set_block(blk_empty, IV);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_hold", {a_out, b_out, c_out, d_out}, held);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        check("release_idle", in_ready, 1);
        out_ready = 1'b0;
        tick();
        check("bp_accept", busy, 1);
        in_valid = 1'b0;
        wait_valid(n);
        check("bp_digest", {a_out, b_out, c_out, d_out}, DIG_EMPTY);
        out_ready = 1'b1;
        tick();

        // Back-to-back: DONE + IDLE + 64 RUN + FINAL = 67 edges between digests
        acc = 0; nv = 0; k = 0;
        while (nv < 2 && k < 400) begin
            in_valid = (acc < 2);
            set_block((acc == 0) ? blk_abc : blk_empty, IV);
            tick();
            k++;
            if (m_acc) acc++;
            if (out_valid) begin
                vt[nv] = k;
                vd[nv] = {a_out, b_out, c_out, d_out};
                nv++;
            end
        end
        in_valid = 1'b0;
        check("b2b_count", nv, 2);
        if (nv == 2) begin
            check("b2b_first", vd[0], DIG_ABC);
            check("b2b_second", vd[1], DIG_EMPTY);
            check("b2b_spacing", vt[1] - vt[0], 67);
        end

        // Reset mid-RUN, with in_valid also offered on the reset edge
        send(blk_empty, IV);
        k = 0;
        while (round_num != 6'd30 && k < 100) begin
            tick();
            k++;
        end
        check("reach_round30", round_num, 30);
        reset = 1'b1;
        set_block(blk_abc, IV);
        in_valid = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_round", round_num, 0);
        stray = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (out_valid) stray++;
        end
        check("no_stray_valid", stray, 0);
        send(blk_empty, IV);
        wait_valid(n);
        check("post_rst_latency", n, 65);
        check("post_rst_digest", {a_out, b_out, c_out, d_out}, DIG_EMPTY);
        out_ready = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
